// File: rtl/gmac_tx_arbiter.sv
`timescale 1ns/1ps
// gmac_tx_arbiter: three-source round-robin arbiter in front of one GMAC
// transmit byte stream, with inter-frame gap and stalled-frame abort.
module gmac_tx_arbiter #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned TIMEOUT    = 2048,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       ReqIn,
  input  logic             ValIn0,
  input  logic             ValIn1,
  input  logic             ValIn2,
  input  logic             SoFIn0,
  input  logic             SoFIn1,
  input  logic             SoFIn2,
  input  logic             EoFIn0,
  input  logic             EoFIn1,
  input  logic             EoFIn2,
  input  logic [7:0]       DataIn0,
  input  logic [7:0]       DataIn1,
  input  logic [7:0]       DataIn2,
  output logic [2:0]       ReqConfirm,
  output logic             ValOut,
  output logic             SoFOut,
  output logic             EoFOut,
  output logic [7:0]       DataOut,
  output logic             AbortOut,
  output logic             Busy,
  output logic [CNT_W-1:0] TimeoutCount
);

  localparam int unsigned IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam int unsigned GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GW'(IFG_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_sel;
  logic [2:0]       r_grant;
  logic [IW-1:0]    r_idle_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_val;
  logic             r_sof;
  logic             r_eof;
  logic             r_abort;
  logic [7:0]       r_data;
  logic [CNT_W-1:0] r_tcount;

  logic       w_found;
  logic [1:0] w_sel;
  logic [1:0] w_idx;
  logic       w_val;
  logic       w_sof;
  logic       w_eof;
  logic [7:0] w_data;

  // Round-robin pick: scan upward from the source after the last grant, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 2'd0;
    w_idx   = r_last;
    for (int unsigned i = 0; i < 3; i++) begin
      w_idx = (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
      if (!w_found && ReqIn[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Select the granted source's stream; other sources are never looked at.
  always_comb begin
    w_val  = 1'b0;
    w_sof  = 1'b0;
    w_eof  = 1'b0;
    w_data = '0;
    case (r_sel)
      2'd0: begin
        w_val  = ValIn0;
        w_sof  = SoFIn0;
        w_eof  = EoFIn0;
        w_data = DataIn0;
      end
      2'd1: begin
        w_val  = ValIn1;
        w_sof  = SoFIn1;
        w_eof  = EoFIn1;
        w_data = DataIn1;
      end
      default: begin
        w_val  = ValIn2;
        w_sof  = SoFIn2;
        w_eof  = EoFIn2;
        w_data = DataIn2;
      end
    endcase
  end

  // Arbitration FSM with registered grant, stream outputs and abort statistics.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_last     <= 2'd2;
      r_sel      <= 2'd0;
      r_grant    <= '0;
      r_idle_cnt <= '0;
      r_gap_cnt  <= '0;
      r_val      <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_abort    <= 1'b0;
      r_data     <= '0;
      r_tcount   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_val   <= 1'b0;
          r_sof   <= 1'b0;
          r_eof   <= 1'b0;
          r_abort <= 1'b0;
          r_data  <= '0;
          if (w_found) begin
            r_sel      <= w_sel;
            r_last     <= w_sel;
            r_grant    <= 3'b001 << w_sel;
            r_idle_cnt <= '0;
            r_state    <= XFER;
          end
        end
        XFER: begin
          r_val   <= w_val;
          r_sof   <= w_sof;
          r_eof   <= w_eof;
          r_data  <= w_data;
          r_abort <= 1'b0;
          if (w_val) begin
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
          // A valid EoF is tested first so it wins over a coincident timeout.
          if (w_val && w_eof) begin
            r_grant <= '0;
            if (IFG_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= GAP_LOAD;
            end
          end else if (!w_val && (r_idle_cnt == IDLE_LAST)) begin
            r_val   <= 1'b1;
            r_sof   <= 1'b0;
            r_eof   <= 1'b1;
            r_abort <= 1'b1;
            r_data  <= '0;
            r_grant <= '0;
            if (r_tcount != '1) begin
              r_tcount <= r_tcount + 1'b1;
            end
            if (IFG_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          r_val   <= 1'b0;
          r_sof   <= 1'b0;
          r_eof   <= 1'b0;
          r_abort <= 1'b0;
          r_data  <= '0;
          if (r_gap_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign ReqConfirm   = r_grant;
  assign ValOut       = r_val;
  assign SoFOut       = r_sof;
  assign EoFOut       = r_eof;
  assign DataOut      = r_data;
  assign AbortOut     = r_abort;
  assign Busy         = (r_state != IDLE);
  assign TimeoutCount = r_tcount;

endmodule

// File: tb/tb_gmac_tx_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for gmac_tx_arbiter: the stimulus process queues the
// expected forwarded beats, a negedge monitor pops and compares them.
module tb_gmac_tx_arbiter;

  logic        CLK;
  logic        RST;
  logic [2:0]  ReqIn;
  logic [2:0]  val;
  logic [2:0]  sof;
  logic [2:0]  eof;
  logic [7:0]  dat [3];
  logic [2:0]  ReqConfirm;
  logic        ValOut;
  logic        SoFOut;
  logic        EoFOut;
  logic [7:0]  DataOut;
  logic        AbortOut;
  logic        Busy;
  logic [15:0] TimeoutCount;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic       abort;
    logic [7:0] data;
  } beat_t;

  beat_t exp_q [$];
  beat_t m_exp;
  int    n_vec = 0;
  int    n_err = 0;

  gmac_tx_arbiter #(
    .IFG_CYCLES (12),
    .TIMEOUT    (8),
    .CNT_W      (16)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ReqIn        (ReqIn),
    .ValIn0       (val[0]),
    .ValIn1       (val[1]),
    .ValIn2       (val[2]),
    .SoFIn0       (sof[0]),
    .SoFIn1       (sof[1]),
    .SoFIn2       (sof[2]),
    .EoFIn0       (eof[0]),
    .EoFIn1       (eof[1]),
    .EoFIn2       (eof[2]),
    .DataIn0      (dat[0]),
    .DataIn1      (dat[1]),
    .DataIn2      (dat[2]),
    .ReqConfirm   (ReqConfirm),
    .ValOut       (ValOut),
    .SoFOut       (SoFOut),
    .EoFOut       (EoFOut),
    .DataOut      (DataOut),
    .AbortOut     (AbortOut),
    .Busy         (Busy),
    .TimeoutCount (TimeoutCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Monitor: every forwarded beat must match the head of the expectation queue.
  always @(negedge CLK) begin
    if (ValOut) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got sof=%0b eof=%0b abort=%0b data=%02h, required no beat",
                 SoFOut, EoFOut, AbortOut, DataOut);
      end else begin
        m_exp = exp_q.pop_front();
        if ({SoFOut, EoFOut, AbortOut, DataOut} !== m_exp) begin
          n_err++;
          $display("FAIL beat: got sof=%0b eof=%0b abort=%0b data=%02h, required sof=%0b eof=%0b abort=%0b data=%02h",
                   SoFOut, EoFOut, AbortOut, DataOut,
                   m_exp.sof, m_exp.eof, m_exp.abort, m_exp.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    ReqIn = '0;
    val   = '0;
    sof   = '0;
    eof   = '0;
    for (int i = 0; i < 3; i++) dat[i] = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Polls (bounded) until any grant appears; cyc counts clock edges waited.
  task automatic wait_grant(output int cyc, output logic [2:0] g);
    cyc = 0;
    while (ReqConfirm == 3'b000 && cyc < 60) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    g = ReqConfirm;
    if (ReqConfirm == 3'b000) begin
      n_vec++;
      n_err++;
      $display("FAIL grant_timeout: got ReqConfirm=000, required a grant within 60 cycles");
    end
  endtask

  // Drives n back-to-back bytes from src and queues each as an expected beat.
  task automatic drive_frame(input int src, input int n, input logic [7:0] base, input bit with_eof);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      val[src] = 1'b1;
      sof[src] = (i == 0);
      eof[src] = with_eof && (i == n - 1);
      dat[src] = base + 8'(i);
      b.sof    = (i == 0);
      b.eof    = with_eof && (i == n - 1);
      b.abort  = 1'b0;
      b.data   = base + 8'(i);
      exp_q.push_back(b);
      @(posedge CLK);
      #1;
    end
    val[src] = 1'b0;
    sof[src] = 1'b0;
    eof[src] = 1'b0;
  endtask

  int         cyc;
  int         cnt;
  logic [2:0] g;
  beat_t      ab;

  initial begin
    RST   = 1'b1;
    ReqIn = '0;
    val   = '0;
    sof   = '0;
    eof   = '0;
    for (int i = 0; i < 3; i++) dat[i] = '0;

    // Reset state.
    do_reset();
    check("reset_outputs",
          {ReqConfirm, ValOut, SoFOut, EoFOut, AbortOut, DataOut, Busy, TimeoutCount}, 32'h0);

    // Single 64-byte frame from source 0, source 1 drives garbage throughout.
    ReqIn = 3'b001;
    wait_grant(cyc, g);
    check("single_grant_latency", 32'(cyc), 32'd1);
    check("single_grant_value", 32'(g), 32'h1);
    ReqIn  = 3'b000;
    val[1] = 1'b1;
    sof[1] = 1'b1;
    eof[1] = 1'b1;
    dat[1] = 8'hEE;
    drive_frame(0, 64, 8'h00, 1'b1);
    check("single_eof_out", 32'(EoFOut), 32'd1);
    check("single_grant_drop", 32'(ReqConfirm), 32'h0);
    val[1] = 1'b0;
    sof[1] = 1'b0;
    eof[1] = 1'b0;
    cnt = 0;
    while (Busy && cnt < 40) begin
      @(posedge CLK);
      #1;
      cnt++;
    end
    check("single_busy_fall", 32'(cnt), 32'd12);

    // Round robin with all requests held.
    do_reset();
    ReqIn = 3'b111;
    for (int f = 0; f < 6; f++) begin
      wait_grant(cyc, g);
      if (f > 0) check("rr_eof_to_grant", 32'(cyc), 32'd13);
      check("rr_grant_order", 32'(g), 32'(3'b001 << (f % 3)));
      if (f == 5) ReqIn = 3'b000;
      case (g)
        3'b001:  drive_frame(0, 4, 8'h10 + 8'(f * 16), 1'b1);
        3'b010:  drive_frame(1, 4, 8'h14 + 8'(f * 16), 1'b1);
        default: drive_frame(2, 4, 8'h18 + 8'(f * 16), 1'b1);
      endcase
    end
    repeat (14) @(posedge CLK);
    #1;

    // Timeout: source 2 sends 3 bytes then stalls.
    do_reset();
    ReqIn = 3'b100;
    wait_grant(cyc, g);
    check("to_grant_value", 32'(g), 32'h4);
    ReqIn = 3'b000;
    drive_frame(2, 3, 8'h50, 1'b0);
    ab.sof   = 1'b0;
    ab.eof   = 1'b1;
    ab.abort = 1'b1;
    ab.data  = 8'h00;
    exp_q.push_back(ab);
    cnt = 1;
    while (!(ValOut && AbortOut) && cnt < 40) begin
      @(posedge CLK);
      #1;
      cnt++;
    end
    check("to_abort_delay", 32'(cnt), 32'd9);
    check("to_grant_drop", 32'(ReqConfirm), 32'h0);
    check("to_count", 32'(TimeoutCount), 32'd1);
    ReqIn = 3'b111;
    wait_grant(cyc, g);
    check("to_next_grant", 32'(g), 32'h1);

    // Reset asserted while byte 10 of a frame from source 0 is presented.
    ReqIn = 3'b000;
    drive_frame(0, 10, 8'h80, 1'b0);
    val[0] = 1'b1;
    dat[0] = 8'h8A;
    RST    = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_mid_outputs",
          {ReqConfirm, ValOut, SoFOut, EoFOut, AbortOut, DataOut, Busy, TimeoutCount}, 32'h0);
    RST    = 1'b0;
    val[0] = 1'b0;
    ReqIn  = 3'b110;
    @(posedge CLK);
    #1;
    check("rst_after_grant", 32'(ReqConfirm), 32'h2);
    ReqIn = 3'b000;
    drive_frame(1, 3, 8'hC0, 1'b1);
    check("rst_after_eof_drop", 32'(ReqConfirm), 32'h0);
    repeat (15) @(posedge CLK);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
